// File: rtl/alu_arbiter_if.sv
// Bundle of request, ALU and response signals shared between the requesters,
// the ALU and alu_arbiter; the arbiter connects through the slave modport.
interface alu_arbiter_if #(
   parameter int BW   = 16,
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*BW-1:0] req_a;
   logic [NREQ*BW-1:0] req_b;
   logic [NREQ*4-1:0]  req_op;

   logic [BW-1:0]      alu_a;
   logic [BW-1:0]      alu_b;
   logic [3:0]         alu_op;
   logic [BW-1:0]      alu_out;
   logic [2:0]         alu_flags;

   logic               rsp_valid;
   logic               rsp_ready;
   logic [IDW-1:0]     rsp_id;
   logic [BW-1:0]      rsp_out;
   logic [2:0]         rsp_flags;
   logic               busy;

   modport slave (
      input  req_valid, req_a, req_b, req_op, alu_out, alu_flags, rsp_ready,
      output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_out,
             rsp_flags, busy
   );

   modport master (
      output req_valid, req_a, req_b, req_op, alu_out, alu_flags, rsp_ready,
      input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_out,
             rsp_flags, busy
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one external combinational ALU between NREQ
// requesters: grant in IDLE, evaluate in EXEC, hold the tagged result in RESP.
module alu_arbiter #(
   parameter int BW   = 16,
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input logic          clk,
   input logic          rst_n,
   alu_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state_q,     state_d;
   logic [IDW-1:0]  ptr_q,       ptr_d;
   logic [BW-1:0]   a_q,         a_d;
   logic [BW-1:0]   b_q,         b_d;
   logic [3:0]      op_q,        op_d;
   logic [IDW-1:0]  gid_q,       gid_d;
   logic            rspValid_q,  rspValid_d;
   logic [IDW-1:0]  rspId_q,     rspId_d;
   logic [BW-1:0]   rspOut_q,    rspOut_d;
   logic [2:0]      rspFlags_q,  rspFlags_d;

   logic            grantFound;
   logic [IDW-1:0]  grantIdx;
   logic [IDW-1:0]  nextPtr;
   logic [NREQ-1:0] reqReady;
   logic            handshake;

   // First valid requester at or after ptr, wrapping around NREQ.
   always_comb begin
      logic [IDW:0] cand;
      grantFound = 1'b0;
      grantIdx   = '0;
      cand       = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, ptr_q} + (IDW+1)'(k);
         if (cand >= (IDW+1)'(NREQ)) begin
            cand = cand - (IDW+1)'(NREQ);
         end
         if (!grantFound && bus.req_valid[cand[IDW-1:0]]) begin
            grantFound = 1'b1;
            grantIdx   = cand[IDW-1:0];
         end
      end
   end

   assign nextPtr   = (grantIdx == IDW'(NREQ-1)) ? '0 : grantIdx + 1'b1;
   assign handshake = |(bus.req_valid & reqReady);

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      a_d        = a_q;
      b_d        = b_q;
      op_d       = op_q;
      gid_d      = gid_q;
      rspValid_d = rspValid_q;
      rspId_d    = rspId_q;
      rspOut_d   = rspOut_q;
      rspFlags_d = rspFlags_q;
      reqReady   = '0;

      case (state_q)
         IDLE: begin
            if (grantFound) begin
               reqReady = NREQ'(1) << grantIdx;
            end
            if (handshake) begin
               a_d     = bus.req_a[grantIdx*BW +: BW];
               b_d     = bus.req_b[grantIdx*BW +: BW];
               op_d    = bus.req_op[grantIdx*4 +: 4];
               gid_d   = grantIdx;
               ptr_d   = nextPtr;
               state_d = EXEC;
            end
         end
         EXEC: begin
            rspOut_d   = bus.alu_out;
            rspFlags_d = bus.alu_flags;
            rspId_d    = gid_q;
            rspValid_d = 1'b1;
            state_d    = RESP;
         end
         RESP: begin
            if (bus.rsp_ready) begin
               rspValid_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Any reset, even mid-operation, drops the in-flight work without a response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         gid_q      <= '0;
         rspValid_q <= 1'b0;
         rspId_q    <= '0;
         rspOut_q   <= '0;
         rspFlags_q <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         a_q        <= a_d;
         b_q        <= b_d;
         op_q       <= op_d;
         gid_q      <= gid_d;
         rspValid_q <= rspValid_d;
         rspId_q    <= rspId_d;
         rspOut_q   <= rspOut_d;
         rspFlags_q <= rspFlags_d;
      end
   end

   // The reset gate keeps req_ready low while rst_n is held, even in IDLE.
   assign bus.req_ready = reqReady & {NREQ{rst_n}};
   assign bus.alu_a     = a_q;
   assign bus.alu_b     = b_q;
   assign bus.alu_op    = op_q;
   assign bus.rsp_valid = rspValid_q;
   assign bus.rsp_id    = rspId_q;
   assign bus.rsp_out   = rspOut_q;
   assign bus.rsp_flags = rspFlags_q;
   assign bus.busy      = (state_q != IDLE);

endmodule
